// File: rtl/obi_core_req_slice_if.sv
// OBI request/response bundle between a core port and the bus.
// The master drives the request fields; the slave returns grant and response.
interface obi_core_req_slice_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/obi_core_req_slice.sv
// Registered OBI request slice with an outstanding-response limit.
// Requests are registered toward the bus; responses pass straight through to the core.
module obi_core_req_slice #(
    parameter int unsigned  MAX_OUTSTANDING = 2,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    obi_core_req_slice_if.slave          slv,
    obi_core_req_slice_if.master         mst,
    output logic                         idle_o,
    output logic                         rsp_unexpected_o
);

    logic             valid_r;
    logic [31:0]      addr_r;
    logic             we_r;
    logic [3:0]       be_r;
    logic [31:0]      wdata_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W:0]   credit_sum_s;
    logic             credit_ok_s;
    logic             cnt_zero_s;
    logic             gnt_s;
    logic             inc_s;
    logic             dec_s;

    // Credit, grant and counter-event decode; the held request counts against credit.
    always_comb begin
        credit_sum_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, valid_r};
        credit_ok_s  = (credit_sum_s < (CNT_W + 1)'(MAX_OUTSTANDING));
        cnt_zero_s   = (cnt_r == {CNT_W{1'b0}});
        gnt_s        = slv.req && credit_ok_s && (!valid_r || mst.gnt);
        inc_s        = valid_r && mst.gnt;
        dec_s        = mst.rvalid && !cnt_zero_s;
    end

    // Outstanding counter next value; simultaneous inc and dec cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({inc_s, dec_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Slice occupancy: a new accept wins over a drain so back-to-back stays full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
        end else if (gnt_s) begin
            valid_r <= 1'b1;
        end else if (inc_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Payload only loads on accept, so it stays stable while the bus withholds gnt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_r  <= 32'h0000_0000;
            we_r    <= 1'b0;
            be_r    <= 4'h0;
            wdata_r <= 32'h0000_0000;
        end else if (gnt_s) begin
            addr_r  <= slv.addr;
            we_r    <= slv.we;
            be_r    <= slv.be;
            wdata_r <= slv.wdata;
        end else begin
            addr_r  <= addr_r;
            we_r    <= we_r;
            be_r    <= be_r;
            wdata_r <= wdata_r;
        end
    end

    // Outstanding-response counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Output mapping; an rvalid with nothing outstanding is flagged and not forwarded.
    always_comb begin
        mst.req          = valid_r;
        mst.addr         = addr_r;
        mst.we           = we_r;
        mst.be           = be_r;
        mst.wdata        = wdata_r;
        slv.gnt          = gnt_s;
        slv.rvalid       = mst.rvalid && !cnt_zero_s;
        slv.rdata        = mst.rdata;
        idle_o           = !valid_r && cnt_zero_s;
        rsp_unexpected_o = mst.rvalid && cnt_zero_s;
    end

endmodule

// File: tb/tb_obi_core_req_slice.sv
// Self-checking bench for obi_core_req_slice: directed scenarios then random traffic,
// compared each cycle against a queue-based transaction model.
module tb_obi_core_req_slice;

    localparam int unsigned MAX = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic clk_i;
    logic rst_ni;
    logic idle_o;
    logic rsp_unexpected_o;

    obi_core_req_slice_if slv_if ();
    obi_core_req_slice_if mst_if ();

    obi_core_req_slice #(.MAX_OUTSTANDING(MAX)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .slv              (slv_if.slave),
        .mst              (mst_if.master),
        .idle_o           (idle_o),
        .rsp_unexpected_o (rsp_unexpected_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int   vectors    = 0;
    int   miscompares = 0;
    txn_t held_q[$];
    txn_t flight_q[$];
    txn_t last_pl;

    function automatic logic [31:0] rhash(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check before posedge, advance the model.
    task automatic cycle(input logic req, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic bgnt, input logic brv, input logic [31:0] brdata);
        logic exp_gnt;
        txn_t cur;
        txn_t nt;
        slv_if.req    = req;
        slv_if.addr   = addr;
        slv_if.we     = we;
        slv_if.be     = be;
        slv_if.wdata  = wdata;
        mst_if.gnt    = bgnt;
        mst_if.rvalid = brv;
        mst_if.rdata  = brdata;
        #1;
        exp_gnt = req && ((held_q.size() + flight_q.size()) < MAX) &&
                  ((held_q.size() == 0) || bgnt);
        cur = (held_q.size() != 0) ? held_q[0] : last_pl;
        chk("gnt",     32'(slv_if.gnt), 32'(exp_gnt));
        chk("mreq",    32'(mst_if.req), 32'(held_q.size() != 0));
        chk("maddr",   mst_if.addr, cur.addr);
        chk("mwe",     32'(mst_if.we), 32'(cur.we));
        chk("mbe",     32'(mst_if.be), 32'(cur.be));
        chk("mwdata",  mst_if.wdata, cur.wdata);
        chk("rvalid",  32'(slv_if.rvalid), 32'(brv && (flight_q.size() != 0)));
        chk("rdata",   slv_if.rdata, brdata);
        chk("unexp",   32'(rsp_unexpected_o), 32'(brv && (flight_q.size() == 0)));
        chk("idle",    32'(idle_o), 32'((held_q.size() == 0) && (flight_q.size() == 0)));
        chk("cnt",     32'(dut.cnt_r), 32'(flight_q.size()));
        if (brv && (flight_q.size() != 0)) void'(flight_q.pop_front());
        if ((held_q.size() != 0) && bgnt) flight_q.push_back(held_q.pop_front());
        if (exp_gnt) begin
            nt = '{addr: addr, we: we, be: be, wdata: wdata};
            held_q.push_back(nt);
            last_pl = nt;
        end
        @(negedge clk_i);
    endtask

    task automatic idle_cycle(input logic bgnt, input logic brv, input logic [31:0] brdata);
        cycle(1'b0, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000, bgnt, brv, brdata);
    endtask

    // Asynchronous reset asserted between clock edges; outputs checked before any edge.
    task automatic do_reset();
        slv_if.req    = 1'b0;
        mst_if.gnt    = 1'b0;
        mst_if.rvalid = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_mreq",  32'(mst_if.req), 32'h0);
        chk("rst_gnt",   32'(slv_if.gnt), 32'h0);
        chk("rst_idle",  32'(idle_o), 32'h1);
        chk("rst_unexp", 32'(rsp_unexpected_o), 32'h0);
        chk("rst_cnt",   32'(dut.cnt_r), 32'h0);
        chk("rst_maddr", mst_if.addr, 32'h0);
        held_q.delete();
        flight_q.delete();
        last_pl = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic        r_req;
        logic [31:0] r_addr;
        logic        r_bgnt;
        logic        r_brv;
        logic [31:0] r_brd;
        rst_ni        = 1'b1;
        slv_if.req    = 1'b0;
        slv_if.addr   = 32'h0;
        slv_if.we     = 1'b0;
        slv_if.be     = 4'h0;
        slv_if.wdata  = 32'h0;
        mst_if.gnt    = 1'b0;
        mst_if.rvalid = 1'b0;
        mst_if.rdata  = 32'h0;
        last_pl       = '0;
        @(negedge clk_i);
        do_reset();

        // Single read
        cycle(1'b1, 32'h0000_0180, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
        idle_cycle(1'b1, 1'b0, 32'h0);
        idle_cycle(1'b0, 1'b0, 32'h0);
        idle_cycle(1'b0, 1'b1, 32'hDEAD_BEEF);
        idle_cycle(1'b0, 1'b0, 32'h0);

        // Back-to-back writes, bus always granting, rvalid two cycles after gnt
        cycle(1'b1, 32'h0000_1000, 1'b1, 4'hF, 32'h1111_0000, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 32'h0000_1004, 1'b1, 4'h3, 32'h2222_0004, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 32'h0000_1008, 1'b1, 4'hC, 32'h3333_0008, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 32'h0000_1008, 1'b1, 4'hC, 32'h3333_0008, 1'b1, 1'b1, 32'h0000_0A00);
        cycle(1'b1, 32'h0000_1008, 1'b1, 4'hC, 32'h3333_0008, 1'b1, 1'b1, 32'h0000_0B00);
        idle_cycle(1'b1, 1'b0, 32'h0);
        idle_cycle(1'b1, 1'b1, 32'h0000_0C00);

        // Downstream stall for five cycles with a second request waiting
        cycle(1'b1, 32'h0000_2000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h0000_2004, 1'b1, 4'h1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h0000_2004, 1'b1, 4'h1, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0);
        idle_cycle(1'b1, 1'b1, 32'h0000_2000);
        idle_cycle(1'b0, 1'b1, 32'h0000_2004);

        // Simultaneous inc/dec, then reset with B outstanding and a stale rvalid
        cycle(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h0000_3004, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
        idle_cycle(1'b1, 1'b1, 32'hAAAA_3000);
        chk("cnt_incdec", 32'(dut.cnt_r), 32'h1);
        do_reset();
        idle_cycle(1'b0, 1'b1, 32'h1234_5678);
        idle_cycle(1'b0, 1'b0, 32'h0);

        // Random traffic with a behavioural bus and one reset in the middle
        for (int i = 0; i < 400; i++) begin
            r_req  = ($urandom_range(0, 99) < 70);
            r_addr = $urandom & 32'hFFFF_FFFC;
            r_bgnt = ($urandom_range(0, 99) < 60);
            if (flight_q.size() != 0) begin
                r_brv = ($urandom_range(0, 99) < 40);
                r_brd = rhash(flight_q[0].addr);
            end else begin
                r_brv = ($urandom_range(0, 99) < 5);
                r_brd = $urandom;
            end
            if (i == 200) do_reset();
            cycle(r_req, r_addr, 1'($urandom), 4'($urandom), $urandom, r_bgnt, r_brv, r_brd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
